sa_feeder: RTL and testbench

Input-side sequencer for the weight-stationary systolic array. It loads a ROWS x COLS weight tile into the array by shifting weight rows down the columns under `control`. It then streams activation vectors into the array rows with the triangular skew the array needs: row i is delayed i cycles. It drives the top edge (weights, `control`) and left edge (activations) of the MAC grid directly, and accepts both operand streams through valid/ready handshakes.

---
 rtl/sa_feeder_if.sv | 24 ++
 rtl/sa_feeder.sv | 117 +++++++++++
 tb/tb_sa_feeder.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sa_feeder_if.sv
// Operand-side handshake bundle for sa_feeder: weight rows and activation vectors.
interface sa_feeder_if #(
  parameter int unsigned bit_width = 8,
  parameter int unsigned ROWS      = 4,
  parameter int unsigned COLS      = 4
);
  logic                      wt_valid;
  logic                      wt_ready;
  logic [COLS*bit_width-1:0] wt_row;
  logic                      act_valid;
  logic                      act_ready;
  logic [ROWS*bit_width-1:0] act_vec;
  logic                      act_last;

  modport master (
    output wt_valid, wt_row, act_valid, act_vec, act_last,
    input  wt_ready, act_ready
  );

  modport slave (
    input  wt_valid, wt_row, act_valid, act_vec, act_last,
    output wt_ready, act_ready
  );
endinterface

// File: rtl/sa_feeder.sv
// Input-side sequencer for the weight-stationary systolic array: loads a weight
// tile under control, then streams activation vectors with a per-row skew.
module sa_feeder #(
  parameter int unsigned bit_width = 8,
  parameter int unsigned ROWS      = 4,
  parameter int unsigned COLS      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  sa_feeder_if.slave                bus,
  output logic [COLS*bit_width-1:0] wt_out,
  output logic                      control,
  output logic [ROWS*bit_width-1:0] data_out,
  output logic                      busy
);

  localparam int unsigned CW = $clog2(ROWS + 1);
  localparam logic [CW-1:0] LAST_ROW   = CW'(ROWS);
  localparam logic [CW-1:0] DRAIN_INIT = CW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;

  state_t        state;
  logic [CW-1:0] wt_cnt;
  logic [CW-1:0] drain_cnt;
  logic          weights_loaded;
  logic          wt_acc;
  logic          act_acc;

  // Readies and busy decode from state; a pending weight row blocks activations in IDLE.
  always_comb begin
    bus.wt_ready  = (state == IDLE) || (state == LOAD);
    bus.act_ready = (state == STREAM) ||
                    ((state == IDLE) && weights_loaded && !bus.wt_valid);
    busy          = (state != IDLE);
  end

  assign wt_acc  = bus.wt_valid  & bus.wt_ready;
  assign act_acc = bus.act_valid & bus.act_ready;

  // Sequencer: tile load counting, stream/drain control and the weight-shift outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      wt_cnt         <= '0;
      drain_cnt      <= '0;
      weights_loaded <= 1'b0;
      wt_out         <= '0;
      control        <= 1'b0;
    end else begin
      control <= wt_acc;
      if (wt_acc) wt_out <= bus.wt_row;
      unique case (state)
        IDLE: begin
          if (wt_acc) begin
            weights_loaded <= (ROWS == 1);
            wt_cnt         <= CW'(1);
            state          <= (ROWS == 1) ? STREAM : LOAD;
          end else if (act_acc) begin
            if (bus.act_last) begin
              drain_cnt <= DRAIN_INIT;
              state     <= (ROWS == 1) ? IDLE : DRAIN;
            end else begin
              state <= STREAM;
            end
          end
        end
        LOAD: begin
          if (wt_acc) begin
            wt_cnt <= wt_cnt + CW'(1);
            if (wt_cnt + CW'(1) == LAST_ROW) begin
              weights_loaded <= 1'b1;
              state          <= STREAM;
            end
          end
        end
        STREAM: begin
          if (act_acc && bus.act_last) begin
            drain_cnt <= DRAIN_INIT;
            state     <= (ROWS == 1) ? IDLE : DRAIN;
          end
        end
        DRAIN: begin
          // Leaving on the count of 1 gives exactly ROWS-1 cycles in DRAIN.
          if (drain_cnt <= CW'(1)) begin
            drain_cnt <= '0;
            state     <= IDLE;
          end else begin
            drain_cnt <= drain_cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    // Stage i of the line doubles as the data_out register, so row i lags by i+1 cycles.
    logic [bit_width-1:0] line [0:i];
    logic [bit_width-1:0] inj;

    assign inj = act_acc ? bus.act_vec[i*bit_width +: bit_width] : '0;

    // Skew line for row i: shifts every cycle, zeros injected when nothing is accepted.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int unsigned k = 0; k <= i; k++) line[k] <= '0;
      end else begin
        line[0] <= inj;
        for (int unsigned k = 1; k <= i; k++) line[k] <= line[k-1];
      end
    end

    assign data_out[i*bit_width +: bit_width] = line[i];
  end

endmodule

// File: tb/tb_sa_feeder.sv
// Self-checking bench for sa_feeder: directed scenarios plus randomized traffic
// against a cycle-indexed reference model of the tile/stream rules.
module tb_sa_feeder;
  localparam int unsigned BW = 8;
  localparam int unsigned R  = 4;
  localparam int unsigned C  = 4;
  localparam int NH = 4096;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sa_feeder_if #(.bit_width(BW), .ROWS(R), .COLS(C)) bus ();

  logic [C*BW-1:0] wt_out;
  logic            control;
  logic [R*BW-1:0] data_out;
  logic            busy;

  sa_feeder #(.bit_width(BW), .ROWS(R), .COLS(C)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .wt_out   (wt_out),
    .control  (control),
    .data_out (data_out),
    .busy     (busy)
  );

  int n_run  = 0;
  int n_fail = 0;

  // Reference model: tile progress flags plus a history of accepted vectors.
  int              cyc = 0;
  int              flush_cyc = -1;
  bit              m_loaded, m_loading, m_streaming, m_ctrl;
  int              m_rows, m_drain;
  logic [C*BW-1:0] m_wt;
  logic [R*BW-1:0] hist_vec [0:NH-1];
  bit              hist_v   [0:NH-1];

  function automatic bit m_idle();
    return !m_loading && !m_streaming && (m_drain == 0);
  endfunction

  function automatic bit exp_wt_ready();
    return !m_streaming && (m_drain == 0);
  endfunction

  function automatic bit exp_act_ready();
    return m_streaming || (m_idle() && m_loaded && (bus.wt_valid !== 1'b1));
  endfunction

  // Element i of the vector accepted in cycle a is on row i during cycle a+1+i.
  function automatic logic [R*BW-1:0] exp_data();
    logic [R*BW-1:0] r;
    int a;
    r = '0;
    for (int i = 0; i < R; i++) begin
      a = cyc - 1 - i;
      if (a > flush_cyc && a >= 0 && hist_v[a]) r[i*BW +: BW] = hist_vec[a][i*BW +: BW];
    end
    return r;
  endfunction

  task automatic set_in(input bit wv, input logic [C*BW-1:0] wr, input bit av,
                        input logic [R*BW-1:0] avec, input bit al);
    bus.wt_valid  = wv;
    bus.wt_row    = wr;
    bus.act_valid = av;
    bus.act_vec   = avec;
    bus.act_last  = al;
  endtask

  // Advance one clock, applying the current inputs to the model.
  task automatic tick();
    bit wacc, aacc, idle_now;
    wacc = !reset && bus.wt_valid && exp_wt_ready();
    aacc = !reset && bus.act_valid && exp_act_ready();
    idle_now = m_idle();
    hist_v[cyc]   = aacc;
    hist_vec[cyc] = bus.act_vec;
    if (reset) begin
      m_loaded = 0; m_loading = 0; m_streaming = 0; m_ctrl = 0;
      m_rows = 0; m_drain = 0; m_wt = '0;
      flush_cyc = cyc;
    end else begin
      m_ctrl = wacc;
      if (wacc) begin
        m_wt = bus.wt_row;
        if (idle_now) begin m_loaded = 0; m_rows = 1; end
        else m_rows++;
        if (m_rows == R) begin m_loaded = 1; m_loading = 0; m_streaming = 1; end
        else m_loading = 1;
      end else if (aacc) begin
        if (bus.act_last) begin m_streaming = 0; m_drain = R - 1; end
        else m_streaming = 1;
      end else if (m_drain > 0) begin
        m_drain--;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    set_in(0, '0, 0, '0, 0);
    #1;
    n_run++; if (wt_out !== '0) begin n_fail++; $display("FAIL rst_wt_out got %h want 0", wt_out); end
    n_run++; if (control !== 1'b0) begin n_fail++; $display("FAIL rst_control got %b want 0", control); end
    n_run++; if (data_out !== '0) begin n_fail++; $display("FAIL rst_data_out got %h want 0", data_out); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    n_run++; if (bus.wt_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wt_ready got %b want 1", bus.wt_ready); end
    n_run++; if (bus.act_ready !== 1'b0) begin n_fail++; $display("FAIL rst_act_ready got %b want 0", bus.act_ready); end
    tick();
  endtask

  task automatic test_load();
    logic [C*BW-1:0] rows [4];
    logic [C*BW-1:0] seen [$];
    int ri = 0;
    int pulses = 0;
    bit wv;
    rows[0] = 32'h11111111; rows[1] = 32'h22222222;
    rows[2] = 32'h33333333; rows[3] = 32'h44444444;
    for (int k = 0; k < 6; k++) begin
      wv = (k == 0 || k == 1 || k == 3 || k == 4);
      set_in(wv, wv ? rows[ri] : 32'hdeadbeef, 0, '0, 0);
      #1;
      n_run++; if (control !== m_ctrl) begin n_fail++; $display("FAIL load_control k=%0d got %b want %b", k, control, m_ctrl); end
      if (control === 1'b1) begin pulses++; seen.push_back(wt_out); end
      if (k == 3) begin
        n_run++; if (control !== 1'b0) begin n_fail++; $display("FAIL load_gap_control got %b want 0", control); end
      end
      if (k == 5) begin
        n_run++; if (bus.act_ready !== 1'b1) begin n_fail++; $display("FAIL load_act_ready_after got %b want 1", bus.act_ready); end
      end
      if (wv) ri++;
      tick();
    end
    n_run++; if (pulses != 4) begin n_fail++; $display("FAIL load_pulses got %0d want 4", pulses); end
    for (int i = 0; i < 4; i++) begin
      n_run++;
      if (i >= seen.size() || seen[i] !== rows[i]) begin
        n_fail++; $display("FAIL load_wt_out_order i=%0d got %h want %h", i, (i < seen.size()) ? seen[i] : 'x, rows[i]);
      end
    end
  endtask

  task automatic test_skew();
    logic [R*BW-1:0] want;
    set_in(0, '0, 1, 32'h04030201, 1);
    #1;
    n_run++; if (bus.act_ready !== 1'b1) begin n_fail++; $display("FAIL skew_act_ready got %b want 1", bus.act_ready); end
    tick();
    for (int k = 1; k <= 4; k++) begin
      set_in(0, '0, 0, '0, 0);
      #1;
      want = '0;
      want[(k-1)*BW +: BW] = 8'(k);
      n_run++; if (data_out !== want) begin n_fail++; $display("FAIL skew_data t+%0d got %h want %h", k, data_out, want); end
      n_run++; if (busy !== (k < 4)) begin n_fail++; $display("FAIL skew_busy t+%0d got %b want %b", k, busy, k < 4); end
      tick();
    end
  endtask

  task automatic test_bubble();
    logic [R*BW-1:0] va, vb;
    va = $urandom() | 32'h01010101;
    vb = $urandom() | 32'h01010101;
    for (int k = 0; k < 3 + R; k++) begin
      case (k)
        0:       set_in(0, '0, 1, va, 0);
        2:       set_in(0, '0, 1, vb, 1);
        default: set_in(0, '0, 0, $urandom(), 0);
      endcase
      #1;
      n_run++; if (data_out !== exp_data()) begin n_fail++; $display("FAIL bubble_data k=%0d got %h want %h", k, data_out, exp_data()); end
      n_run++; if (control !== 1'b0) begin n_fail++; $display("FAIL bubble_control k=%0d got %b want 0", k, control); end
      for (int i = 0; i < R; i++) begin
        if (k == 2 + i) begin
          n_run++;
          if (data_out[i*BW +: BW] !== 8'h00) begin n_fail++; $display("FAIL bubble_gap row=%0d got %h want 00", i, data_out[i*BW +: BW]); end
        end
      end
      tick();
    end
  endtask

  task automatic test_reuse_priority();
    logic [C*BW-1:0] row;
    set_in(0, '0, 1, $urandom(), 1);
    #1;
    n_run++; if (bus.act_ready !== 1'b1) begin n_fail++; $display("FAIL reuse_act_ready got %b want 1", bus.act_ready); end
    tick();
    for (int k = 0; k < R; k++) begin
      set_in(0, '0, 0, '0, 0);
      #1;
      n_run++; if (control !== 1'b0) begin n_fail++; $display("FAIL reuse_control k=%0d got %b want 0", k, control); end
      n_run++; if (data_out !== exp_data()) begin n_fail++; $display("FAIL reuse_data k=%0d got %h want %h", k, data_out, exp_data()); end
      tick();
    end
    row = $urandom();
    set_in(1, row, 1, $urandom(), 0);
    #1;
    n_run++; if (bus.act_ready !== 1'b0) begin n_fail++; $display("FAIL prio_act_ready got %b want 0", bus.act_ready); end
    n_run++; if (bus.wt_ready !== 1'b1) begin n_fail++; $display("FAIL prio_wt_ready got %b want 1", bus.wt_ready); end
    tick();
    for (int k = 0; k < R - 1; k++) begin
      set_in(1, $urandom(), 1, $urandom(), 0);
      #1;
      if (k == 0) begin
        n_run++; if (busy !== 1'b1) begin n_fail++; $display("FAIL prio_busy got %b want 1", busy); end
        n_run++; if (control !== 1'b1 || wt_out !== row) begin n_fail++; $display("FAIL prio_wt_out got %b/%h want 1/%h", control, wt_out, row); end
      end
      n_run++; if (bus.act_ready !== 1'b0) begin n_fail++; $display("FAIL prio_load_act_ready k=%0d got %b want 0", k, bus.act_ready); end
      tick();
    end
    set_in(0, '0, 1, $urandom(), 1);
    #1;
    n_run++; if (bus.act_ready !== 1'b1) begin n_fail++; $display("FAIL prio_stream_act_ready got %b want 1", bus.act_ready); end
    tick();
    for (int k = 0; k < R; k++) begin
      set_in(0, '0, 0, '0, 0);
      #1;
      n_run++; if (data_out !== exp_data()) begin n_fail++; $display("FAIL prio_drain_data k=%0d got %h want %h", k, data_out, exp_data()); end
      tick();
    end
  endtask

  task automatic test_reset_load();
    for (int k = 0; k < 2; k++) begin set_in(1, $urandom(), 0, '0, 0); tick(); end
    reset = 1'b1; set_in(0, '0, 0, '0, 0); tick(); reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_in(0, '0, 1, $urandom(), 0);
      #1;
      n_run++; if (bus.act_ready !== 1'b0) begin n_fail++; $display("FAIL rload_idle_act_ready k=%0d got %b want 0", k, bus.act_ready); end
      n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rload_busy k=%0d got %b want 0", k, busy); end
      tick();
    end
    for (int k = 0; k < R; k++) begin
      set_in(1, $urandom(), 1, $urandom(), 0);
      #1;
      n_run++; if (bus.act_ready !== 1'b0) begin n_fail++; $display("FAIL rload_load_act_ready k=%0d got %b want 0", k, bus.act_ready); end
      tick();
    end
    set_in(0, '0, 1, $urandom(), 0);
    #1;
    n_run++; if (bus.act_ready !== 1'b1) begin n_fail++; $display("FAIL rload_stream_act_ready got %b want 1", bus.act_ready); end
    tick();
  endtask

  task automatic test_reset_stream();
    set_in(0, '0, 1, $urandom() | 32'h01010101, 0);
    tick();
    reset = 1'b1;
    set_in(0, '0, 0, '0, 0);
    tick(); tick();
    reset = 1'b0;
    #1;
    n_run++; if (data_out !== '0) begin n_fail++; $display("FAIL rstr_data got %h want 0", data_out); end
    n_run++; if (control !== 1'b0) begin n_fail++; $display("FAIL rstr_control got %b want 0", control); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstr_busy got %b want 0", busy); end
    n_run++; if (bus.wt_ready !== 1'b1) begin n_fail++; $display("FAIL rstr_wt_ready got %b want 1", bus.wt_ready); end
    n_run++; if (bus.act_ready !== 1'b0) begin n_fail++; $display("FAIL rstr_act_ready got %b want 0", bus.act_ready); end
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      reset = ($urandom_range(0, 99) == 0);
      set_in($urandom_range(0, 1) == 1, $urandom(), $urandom_range(0, 3) != 0, $urandom(),
             $urandom_range(0, 5) == 0);
      #1;
      n_run++; if (bus.wt_ready !== exp_wt_ready()) begin n_fail++; $display("FAIL rnd_wt_ready k=%0d got %b want %b", k, bus.wt_ready, exp_wt_ready()); end
      n_run++; if (bus.act_ready !== exp_act_ready()) begin n_fail++; $display("FAIL rnd_act_ready k=%0d got %b want %b", k, bus.act_ready, exp_act_ready()); end
      n_run++; if (busy !== !m_idle()) begin n_fail++; $display("FAIL rnd_busy k=%0d got %b want %b", k, busy, !m_idle()); end
      n_run++; if (control !== m_ctrl) begin n_fail++; $display("FAIL rnd_control k=%0d got %b want %b", k, control, m_ctrl); end
      n_run++; if (wt_out !== m_wt) begin n_fail++; $display("FAIL rnd_wt_out k=%0d got %h want %h", k, wt_out, m_wt); end
      n_run++; if (data_out !== exp_data()) begin n_fail++; $display("FAIL rnd_data k=%0d got %h want %h", k, data_out, exp_data()); end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    m_loaded = 0; m_loading = 0; m_streaming = 0; m_ctrl = 0;
    m_rows = 0; m_drain = 0; m_wt = '0;
    for (int i = 0; i < NH; i++) hist_v[i] = 0;
    reset = 1'b1;
    set_in(0, '0, 0, '0, 0);
    tick(); tick();
    reset = 1'b0;
    test_reset();
    test_load();
    test_skew();
    test_bubble();
    test_reuse_priority();
    test_reset_load();
    test_reset_stream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
